// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and constants for the instruction/data port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int WORD_W = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_counter
// Description : Saturating count of data grants made while a fetch is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int c_cnt_w = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(LIMIT);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_port_arbiter
// Description : Shares one variable-latency memory port between fetch and data.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter
    import proc_pkg::*;
#(
    parameter int WIDTH        = WORD_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             redirect,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_instr,
    output logic             dm_valid,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             stallF,
    output logic             stallM
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_is_fetch;
    logic             r_drop;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [WIDTH-1:0] r_if_instr;
    logic [WIDTH-1:0] r_dm_rdata;
    logic             w_grant_if;
    logic             w_grant_dm;
    logic             w_at_limit;
    logic             w_starve_inc;
    logic             w_starve_clr;

    // A stale PC (redirect) can never be granted; data otherwise wins unless fetch is starved.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        if (r_state == IDLE) begin
            w_grant_if = if_req && !redirect && (!dm_req || w_at_limit);
            w_grant_dm = dm_req && !w_grant_if;
        end
    end

    assign w_starve_inc = w_grant_dm && if_req;
    assign w_starve_clr = w_grant_if || ((r_state == IDLE) && !if_req);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_starve_inc),
        .clr      (w_starve_clr),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_dm) begin
                    w_state_nxt = DM_BUSY;
                end else if (w_grant_if) begin
                    w_state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (mem_ready) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_fetch  <= 1'b0;
            r_drop      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_instr  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_grant_dm) begin
                r_is_fetch  <= 1'b0;
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_grant_if) begin
                r_is_fetch  <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= dm_wdata;
            end
            if ((r_state == IF_BUSY) && mem_ready) begin
                r_if_instr <= mem_rdata;
            end
            if ((r_state == DM_BUSY) && mem_ready && !r_mem_we) begin
                r_dm_rdata <= mem_rdata;
            end
            // The fetch in flight still runs to completion; only its delivery is suppressed.
            if ((r_state == IF_BUSY) && redirect) begin
                r_drop <= 1'b1;
            end else if (r_state == RESP) begin
                r_drop <= 1'b0;
            end
        end
    end

    always_comb begin
        mem_req  = (r_state == IF_BUSY) || (r_state == DM_BUSY);
        if_valid = (r_state == RESP) && r_is_fetch && !r_drop && !redirect;
        dm_valid = (r_state == RESP) && !r_is_fetch;
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_instr  = r_if_instr;
    assign dm_rdata  = r_dm_rdata;
    assign stallF    = if_req & ~if_valid;
    assign stallM    = dm_req & ~dm_valid;

endmodule
`default_nettype wire
